pipeline_stall_ctrl: RTL

//  Central stall sequencer for the 5-stage pipeline (PC, IF/ID, ID/EX, EX/MEM, MEM/WB, WB).

---
 rtl/pipeline_stall_ctrl_pkg.sv | 34 +++
 rtl/pipeline_stall_ctrl_mc_countdown.sv | 29 ++
 rtl/pipeline_stall_ctrl.sv | 117 +++++++++++
 3 files changed

// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared constants for the pipeline stall sequencer: stall vectors, stall bit
// positions, controller state encodings and the priority merge helper.
package pipeline_stall_ctrl_pkg;

    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_EX   = 6'b001111;
    localparam logic [5:0] STALL_MEM  = 6'b011111;

    localparam int STALL_BIT_PC     = 0;
    localparam int STALL_BIT_IF_ID  = 1;
    localparam int STALL_BIT_ID_EX  = 2;
    localparam int STALL_BIT_EX_MEM = 3;
    localparam int STALL_BIT_MEM_WB = 4;
    localparam int STALL_BIT_WB     = 5;

    localparam logic [1:0] CTRL_IDLE    = 2'd0;
    localparam logic [1:0] CTRL_MC_RUN  = 2'd1;
    localparam logic [1:0] CTRL_MC_DONE = 2'd2;

    // Later stages win: a memory stall must also freeze everything upstream.
    function automatic logic [5:0] stall_vec(input logic mem_req, input logic ex_req,
                                             input logic id_req);
        if (mem_req)
            return STALL_MEM;
        else if (ex_req)
            return STALL_EX;
        else if (id_req)
            return STALL_ID;
        else
            return STALL_NONE;
    endfunction

endpackage

// File: rtl/pipeline_stall_ctrl_mc_countdown.sv
// Load/decrement/freeze counter that tracks the remaining multi-cycle EX stall.
// Decrement is suppressed at zero so the count can never wrap.
module mc_countdown #(
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             cnt_zero,
    output logic             cnt_one
);

    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt_reg <= '0;
        else if (load)
            cnt_reg <= load_val;
        else if (dec && !cnt_zero)
            cnt_reg <= cnt_reg - CNT_W'(1);
    end

    assign cnt_zero = (cnt_reg == '0);
    assign cnt_one  = (cnt_reg == CNT_W'(1));

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Central stall sequencer: merges decode/execute/memory stall requests and runs the
// multi-cycle EX countdown. Optional perf counters when PIPE_STALL_CNT_EN is defined.
module pipeline_stall_ctrl
    import pipeline_stall_ctrl_pkg::*;
#(
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_stallreq,
    input  logic             ex_mc_start,
    input  logic [CNT_W-1:0] ex_mc_len,
    input  logic             mem_stallreq,
    output logic [5:0]       stall,
    output logic             ex_mc_done,
    output logic             busy
`ifdef PIPE_STALL_CNT_EN
    ,
    output logic [31:0]      stall_cycles,
    output logic [15:0]      mc_ops
`endif
);

    logic [1:0] state_reg;
    logic [1:0] state_next;
    logic       done_reg;
    logic       ex_stall;
    logic       cnt_load;
    logic       cnt_dec;
    logic       cnt_zero;
    logic       cnt_one;
    logic       mc_entry;

    assign mc_entry = (state_reg == CTRL_IDLE) && ex_mc_start && (ex_mc_len != '0);

    mc_countdown #(
        .CNT_W (CNT_W)
    ) u_countdown (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (ex_mc_len - CNT_W'(1)),
        .dec      (cnt_dec),
        .cnt_zero (cnt_zero),
        .cnt_one  (cnt_one)
    );

    always_comb begin
        state_next = state_reg;
        ex_stall   = 1'b0;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;
        case (state_reg)
            CTRL_IDLE: begin
                // Entry is taken even under a memory stall; the op has already been seen.
                if (mc_entry) begin
                    ex_stall = 1'b1;
                    if (ex_mc_len == CNT_W'(1)) begin
                        state_next = CTRL_MC_DONE;
                    end else begin
                        cnt_load   = 1'b1;
                        state_next = CTRL_MC_RUN;
                    end
                end
            end
            CTRL_MC_RUN: begin
                ex_stall = 1'b1;
                if (!mem_stallreq) begin
                    cnt_dec = 1'b1;
                    if (cnt_one || cnt_zero)
                        state_next = CTRL_MC_DONE;
                end
            end
            CTRL_MC_DONE: begin
                if (!mem_stallreq)
                    state_next = CTRL_IDLE;
            end
            default: state_next = CTRL_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= CTRL_IDLE;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            done_reg  <= (state_next == CTRL_MC_DONE);
        end
    end

    // Held at zero while reset is asserted so no stage is frozen during reset.
    assign stall      = rst ? stall_vec(mem_stallreq, ex_stall, id_stallreq) : STALL_NONE;
    assign ex_mc_done = done_reg;
    assign busy       = (state_reg != CTRL_IDLE);

`ifdef PIPE_STALL_CNT_EN
    logic [31:0] stall_cycles_reg;
    logic [15:0] mc_ops_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles_reg <= '0;
            mc_ops_reg       <= '0;
        end else begin
            if ((stall != STALL_NONE) && (stall_cycles_reg != '1))
                stall_cycles_reg <= stall_cycles_reg + 32'd1;
            if (mc_entry && (mc_ops_reg != '1))
                mc_ops_reg <= mc_ops_reg + 16'd1;
        end
    end

    assign stall_cycles = stall_cycles_reg;
    assign mc_ops       = mc_ops_reg;
`endif

endmodule
